// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU control path and the data-memory
// responder. The master issues lb/lw/sb/sw requests; the slave answers with
// a single done pulse carrying read data or an error flag.
interface data_mem_if #(
    parameter int ADDR_W = 16
) ();
    logic              req;
    logic              wmem;
    logic              memc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              ready;
    logic              done;
    logic [15:0]       rdata;
    logic              err;

    modport master (
        output req, wmem, memc, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, wmem, memc, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the 16-bit CPU: byte-addressed, little-endian
// storage serving lb/lw/sb/sw. Misaligned halfwords are split into two byte
// cycles (ACC0 then ACC1). Out-of-range requests complete with err=1.
// Optional macro MISALIGN_TRAP_EN: when defined, misaligned halfword requests
// are rejected with err=1 instead of being split.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;

    // Request latched at accept; later bus changes do not affect it.
    logic              wmem_r;
    logic              memc_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;

    // Result being assembled, published to rdata/err in RESP.
    logic [15:0]       res_r;
    logic [15:0]       res_s;
    logic              res_err_r;
    logic              res_err_s;

    logic              ready_r;
    logic              ready_s;
    logic              done_r;
    logic              done_s;
    logic [15:0]       rdata_r;
    logic [15:0]       rdata_s;
    logic              err_r;
    logic              err_s;

    logic              accept_s;
    logic              misalign_s;
    logic              valid_s;
    logic              wr_lo_s;
    logic              wr_hi_s;
    logic [ADDR_W:0]   addr_ext_s;
    logic [ADDR_W:0]   addr_inc_s;
    logic [IDX_W-1:0]  idx_lo_s;
    logic [IDX_W-1:0]  idx_hi_s;
    logic [7:0]        byte_lo_s;
    logic [7:0]        byte_hi_s;

    logic [7:0]        mem_r [DEPTH_BYTES];

    assign accept_s   = bus.req && ready_r;
    assign misalign_s = memc_r && addr_r[0];

    assign bus.ready  = ready_r;
    assign bus.done   = done_r;
    assign bus.rdata  = rdata_r;
    assign bus.err    = err_r;

    // Range check of the latched request and storage read ports.
    always_comb begin
        addr_ext_s = {1'b0, addr_r};
        addr_inc_s = addr_ext_s + {{ADDR_W{1'b0}}, 1'b1};
        if (memc_r) begin
            valid_s = (addr_inc_s < DEPTH_C);
        end else begin
            valid_s = (addr_ext_s < DEPTH_C);
        end
`ifdef MISALIGN_TRAP_EN
        valid_s = valid_s && !misalign_s;
`else
        valid_s = valid_s;
`endif
        idx_lo_s  = addr_r[IDX_W-1:0];
        idx_hi_s  = idx_lo_s + {{(IDX_W-1){1'b0}}, 1'b1};
        byte_lo_s = mem_r[idx_lo_s];
        byte_hi_s = mem_r[idx_hi_s];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = ACC0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACC0: begin
                if (valid_s && misalign_s) begin
                    state_nx_s = ACC1;
                end else begin
                    state_nx_s = RESP;
                end
            end
            ACC1:    state_nx_s = RESP;
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered outputs, result and write strobes.
    always_comb begin
        ready_s   = ready_r;
        done_s    = 1'b0;
        rdata_s   = rdata_r;
        err_s     = err_r;
        res_s     = res_r;
        res_err_s = res_err_r;
        wr_lo_s   = 1'b0;
        wr_hi_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            ACC0: begin
                if (!valid_s) begin
                    res_s     = 16'h0000;
                    res_err_s = 1'b1;
                end else begin
                    res_err_s = 1'b0;
                    if (wmem_r) begin
                        res_s   = 16'h0000;
                        wr_lo_s = 1'b1;
                        wr_hi_s = memc_r && !addr_r[0];
                    end else if (!memc_r) begin
                        res_s = {{8{byte_lo_s[7]}}, byte_lo_s};
                    end else if (!addr_r[0]) begin
                        res_s = {byte_hi_s, byte_lo_s};
                    end else begin
                        res_s = {8'h00, byte_lo_s};
                    end
                end
            end
            ACC1: begin
                if (wmem_r) begin
                    res_s   = 16'h0000;
                    wr_hi_s = 1'b1;
                end else begin
                    res_s = {byte_hi_s, res_r[7:0]};
                end
            end
            RESP: begin
                ready_s = 1'b0;
                done_s  = 1'b1;
                rdata_s = res_r;
                err_s   = res_err_r;
            end
            default: begin
                ready_s = 1'b1;
            end
        endcase
    end

    // Registered outputs and the in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            rdata_r   <= 16'h0000;
            err_r     <= 1'b0;
            res_r     <= 16'h0000;
            res_err_r <= 1'b0;
        end else begin
            ready_r   <= ready_s;
            done_r    <= done_s;
            rdata_r   <= rdata_s;
            err_r     <= err_s;
            res_r     <= res_s;
            res_err_r <= res_err_s;
        end
    end

    // Capture the request on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wmem_r  <= 1'b0;
            memc_r  <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 16'h0000;
        end else if (accept_s) begin
            wmem_r  <= bus.wmem;
            memc_r  <= bus.memc;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
        end
    end

    // Byte storage; contents survive reset, but reset blocks any write that cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_lo_s) begin
            mem_r[idx_lo_s] <= wdata_r[7:0];
        end
        if (!rst && wr_hi_s) begin
            mem_r[idx_hi_s] <= wdata_r[15:8];
        end
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the 16-bit CPU. It executes the load and store requests that the control path issues: lb, lw, sb and sw.
- It accepts one request per handshake and stores the data as bytes, little-endian.
- A misaligned halfword access is carried out as two byte cycles.
- Every completed request produces a single done pulse carrying the read data or an error flag.

Parameters:
- DEPTH_BYTES, 256: number of byte locations. Valid addresses are 0..DEPTH_BYTES-1.
- ADDR_W, 16: width of the address port.

Ports:
- clk  in  1: clock. All state changes happen on the rising edge.
- rst  in  1: synchronous reset, active-high.
- req  in  1: request valid. Sampled only while ready=1.
- wmem  in  1: 0 = read, 1 = write. Same meaning as the control path signal.
- memc  in  1: 0 = byte access, 1 = halfword (2-byte) access.
- addr  in  ADDR_W: byte address.
- wdata  in  16: write data. Byte writes use wdata[7:0].
- ready  out  1: responder is idle and will accept a request.
- done  out  1: one-cycle completion pulse.
- rdata  out  16: read result. Valid while done=1.
- err  out  1: request rejected. Valid while done=1.

Behaviour:
- Reset: one clock, synchronous reset (rst), active-high.
  - After reset: state IDLE, ready=1, done=0, rdata=0, err=0.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, ACC0, ACC1, RESP. All outputs are registered.
- IDLE:
  - If req&ready, latch wmem, memc, addr and wdata. Then ready<=0 and go to ACC0.
  - If req=0, stay in IDLE.
- Validity check, done in ACC0 before any storage access:
  - Byte request: addr>=DEPTH_BYTES is an error.
  - Halfword request: addr+1>=DEPTH_BYTES is an error. There is no wrap-around.
  - On error: no storage access, err<=1, go to RESP.
- ACC0:
  - Read or write byte addr. Halfword accesses also use byte addr+1 in this cycle when addr[0]=0.
  - Aligned halfword or any byte access: go to RESP.
  - Misaligned halfword (memc=1, addr[0]=1): go to ACC1.
- ACC1: read or write byte addr+1, then go to RESP.
- Halfword data layout (little-endian):
  - Write: mem[addr]=wdata[7:0], mem[addr+1]=wdata[15:8].
  - Read: rdata={mem[addr+1],mem[addr]}.
- Byte read: rdata is mem[addr] sign-extended to 16 bits.
- Write: rdata<=0.
- RESP:
  - done=1 for exactly one cycle with rdata and err.
  - Next cycle: done=0, ready=1, state IDLE. rdata and err hold their values until the next RESP.
- Latency from the accept edge to done high:
  - 2 cycles for byte, aligned halfword and error cases.
  - 3 cycles for a misaligned halfword.
- Input changes after acceptance are ignored, because the request was latched.
- req while ready=0 is ignored. The requester must hold req until it sees ready.
- Simultaneous done and a new req: ready is still 0 in RESP, so the new req is accepted in the following IDLE cycle.
- Reset during ACC1 of a misaligned write: the byte already written in ACC0 stays committed. The second byte is not written and no done is issued.
- Reset overrides all other activity in the same cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a halfword request with addr[0]=1 is an error. There is no storage access, err=1, latency is 2, and ACC1 is unreachable.
- Undefined: misaligned halfwords are split into two byte cycles as described under Behaviour.

Test Plan:
- Reset then idle: drive rst for one cycle -> ready=1, done=0, rdata=0, err=0. Contents written before reset read back unchanged.
- Aligned halfword: sw addr=0x0010 wdata=0xBEEF, then lw 0x0010 -> done 2 cycles after each accept, rdata=0xBEEF. lb 0x0010 -> 0xFFEF. lb 0x0011 -> 0xFFBE.
- Byte store/load: sb addr=0x0005 wdata=0x1234 -> only mem[5]=0x34 is written. lb 0x0005 -> rdata=0x0034, err=0.
- Misaligned halfword: sw 0x0021 wdata=0xA55A -> done 3 cycles after accept, mem[0x21]=0x5A, mem[0x22]=0xA5. lw 0x0021 -> 0xA55A. With MISALIGN_TRAP_EN defined: err=1 at 2 cycles and memory is unchanged.
- Bounds: lw 0x00FF with DEPTH_BYTES=256 -> err=1, rdata=0, mem[0xFF] unchanged. lb 0x0100 -> err=1.
- Handshake and reset: hold req during ACC0/RESP -> only one transaction is performed. Assert rst in ACC1 of sw 0x0031 wdata=0x7788 -> no done, mem[0x31]=0x88, mem[0x32] unchanged, ready=1 on the cycle after reset.
